// File: rtl/micro_ucr_hash_pkg.sv
// Shared definitions for the micro_ucr nonce-search slice.
// Holds the controller state encoding, the byte layout of the 16-byte block
// presented to the hash core, the default hash latency, and a helper that
// packs {header, nonce} into that block.
package micro_ucr_hash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_HASH  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int unsigned HASH_LAT_DEF  = 4;
  localparam int unsigned HDR_BYTES     = 12;
  localparam int unsigned NONCE_BYTES   = 4;
  // Block byte that carries nonce[31:24]; following bytes carry lower nonce bytes.
  localparam int unsigned NONCE_BYTE_LO = HDR_BYTES;
  localparam int unsigned BLOCK_BYTES   = HDR_BYTES + NONCE_BYTES;

  // Byte i of the block lands on array_numbers i of the core. Header bytes
  // map straight through; the nonce is placed most-significant byte first.
  function automatic logic [8*BLOCK_BYTES-1:0] build_block(
    input logic [8*HDR_BYTES-1:0]   hdr,
    input logic [8*NONCE_BYTES-1:0] nonce
  );
    logic [8*BLOCK_BYTES-1:0] blk;
    blk = '0;
    blk[8*HDR_BYTES-1:0] = hdr;
    for (int unsigned i = 0; i < NONCE_BYTES; i++) begin
      blk[8*(NONCE_BYTE_LO+i) +: 8] = nonce[8*(NONCE_BYTES-1-i) +: 8];
    end
    return blk;
  endfunction

endpackage

// File: rtl/micro_ucr_wait_timer.sv
// Clear-able up-counter used to wait out the hash core latency.
// Counts while enabled and stops at HASH_LAT-1, where o_tc is raised.
// Ports:
//   clk      in  clock, rising edge
//   reset    in  synchronous active-high reset
//   i_clear  in  return the count to zero
//   i_en     in  advance the count (ignored once terminal count is reached)
//   o_tc     out count == HASH_LAT-1
module micro_ucr_wait_timer #(
  parameter int unsigned HASH_LAT = 4,
  parameter int unsigned CNT_W    = $clog2(HASH_LAT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(HASH_LAT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != TC_VAL)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/micro_ucr_nonce_ctrl.sv
// Nonce-search sequencer for the micro_ucr hash core.
// Latches a 96-bit header and 8-bit target on start, then for each nonce
// presents {nonce, header} to the core, pulses core_ready, waits HASH_LAT
// cycles and evaluates the hash. Stops on the first nonce whose hash bytes
// 0 and 1 are both below target, or after NONCE_LIMIT has been tried.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             one-cycle request, honoured in IDLE or DONE
//   abort             return to IDLE from any state
//   header, target    search inputs, latched when start is accepted
//   hash_array0..2    core result bytes
//   core_ready        one-cycle start pulse to the core
//   core_block        16-byte block to the core (header bytes 0..11, nonce 12..15)
//   busy, done, found search status
//   nonce_out         winning nonce, or last nonce tried on exhaustion
//   hash_out          {hash_array2, hash_array1, hash_array0} of nonce_out
//   attempts          hashes evaluated in the current search (saturating)
module micro_ucr_nonce_ctrl
  import micro_ucr_hash_pkg::*;
#(
  parameter int unsigned HASH_LAT    = HASH_LAT_DEF,
  parameter logic [31:0] NONCE_LIMIT = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [95:0]  header,
  input  logic [7:0]   target,
  input  logic [7:0]   hash_array0,
  input  logic [7:0]   hash_array1,
  input  logic [7:0]   hash_array2,
  output logic         core_ready,
  output logic [127:0] core_block,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [31:0]  nonce_out,
  output logic [23:0]  hash_out,
  output logic [31:0]  attempts
);

  state_t r_state;
  state_t w_state_nxt;

  logic [95:0] r_header;
  logic [7:0]  r_target;
  logic [31:0] r_nonce;
  logic        r_found;
  logic [31:0] r_nonce_out;
  logic [23:0] r_hash_out;
  logic [31:0] r_attempts;

  logic w_accept;
  logic w_timer_clear;
  logic w_timer_en;
  logic w_timer_tc;
  logic w_hit;
  logic w_last;

  micro_ucr_wait_timer #(
    .HASH_LAT (HASH_LAT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_timer_clear),
    .i_en    (w_timer_en),
    .o_tc    (w_timer_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_timer_clear = 1'b0;
    w_timer_en    = 1'b0;
    w_hit         = (hash_array0 < r_target) && (hash_array1 < r_target);
    w_last        = (r_nonce == NONCE_LIMIT);
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_LOAD;
          end
        end
        ST_LOAD: begin
          w_timer_clear = 1'b1;
          w_state_nxt   = ST_HASH;
        end
        ST_HASH: begin
          w_timer_en = 1'b1;
          if (w_timer_tc) begin
            w_state_nxt = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_hit || w_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Abort leaves nonce_out/hash_out/attempts untouched and only drops found;
  // the result latches are written solely on the terminal CHECK.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_header    <= '0;
      r_target    <= '0;
      r_nonce     <= '0;
      r_found     <= 1'b0;
      r_nonce_out <= '0;
      r_hash_out  <= '0;
      r_attempts  <= '0;
    end else if (abort) begin
      r_found <= 1'b0;
    end else begin
      if (w_accept) begin
        r_header   <= header;
        r_target   <= target;
        r_nonce    <= '0;
        r_attempts <= '0;
        r_found    <= 1'b0;
      end
      if (r_state == ST_CHECK) begin
        if (r_attempts != '1) begin
          r_attempts <= r_attempts + 32'd1;
        end
        if (w_hit) begin
          r_found     <= 1'b1;
          r_nonce_out <= r_nonce;
          r_hash_out  <= {hash_array2, hash_array1, hash_array0};
        end else if (w_last) begin
          r_found     <= 1'b0;
          r_nonce_out <= r_nonce;
          r_hash_out  <= {hash_array2, hash_array1, hash_array0};
        end else begin
          r_nonce <= r_nonce + 32'd1;
        end
      end
    end
  end

  // The block is a pure function of latched header and current nonce, which
  // only change on accept or CHECK, so it is stable through LOAD and HASH.
  assign core_block = build_block(r_header, r_nonce);
  assign core_ready = (r_state == ST_LOAD);
  assign busy       = (r_state == ST_LOAD) || (r_state == ST_HASH) || (r_state == ST_CHECK);
  assign done       = (r_state == ST_DONE);
  assign found      = r_found;
  assign nonce_out  = r_nonce_out;
  assign hash_out   = r_hash_out;
  assign attempts   = r_attempts;

endmodule
